// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads, tracks them in a tag pipeline and
// buffers returned instructions in a FIFO. Optional macro: FETCH_UNIT_MISALIGN_EN.
module fetch_unit #(
  parameter int unsigned      PC_W     = 64,
  parameter int unsigned      ADDR_W   = 14,
  parameter int unsigned      INSN_W   = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      MEM_LAT  = 1,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_mem_read,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [INSN_W-1:0] i_mem_data,
  output logic              o_valid,
  output logic [INSN_W-1:0] o_insn,
  output logic [PC_W-1:0]   o_pc,
  input  logic              i_ready,
  input  logic              i_redirect,
  input  logic [PC_W-1:0]   i_redirect_pc,
  output logic              o_fault
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OUT_W = $clog2(DEPTH + MEM_LAT + 1) + 1;

  logic [PC_W-1:0]   pc;
  logic [MEM_LAT:0]  tag_v;
  logic [PC_W-1:0]   tag_pc [MEM_LAT+1];
  logic [INSN_W-1:0] q_insn [DEPTH];
  logic [PC_W-1:0]   q_pc   [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              misaligned;
  logic [PC_W-1:0]   redirect_pc;

`ifdef FETCH_UNIT_MISALIGN_EN
  assign redirect_pc = i_redirect_pc;
  assign misaligned  = |i_redirect_pc[1:0];
`else
  assign redirect_pc = i_redirect_pc & ~PC_W'(3);
  assign misaligned  = 1'b0;
`endif

  logic              enq;
  logic              deq;
  logic [CNT_W-1:0]  count_rem;
  logic [CNT_W-1:0]  count_nxt;
  logic [PTR_W-1:0]  head_nxt;
  logic [OUT_W-1:0]  pending;
  logic [PC_W-1:0]   pc_src;
  logic              fault_nxt;
  logic              issue_nxt;
  logic              head_ok;
  logic [INSN_W-1:0] head_insn;
  logic [PC_W-1:0]   head_pc;

  // Space is reserved at issue: queued entries plus requests that will still
  // be outstanding after this edge must leave room for the new request.
  always_comb begin
    enq       = tag_v[MEM_LAT];
    deq       = o_valid & i_ready;
    count_rem = count - CNT_W'(deq);
    head_nxt  = head + PTR_W'(deq);
    count_nxt = count_rem + CNT_W'(enq);
    pending   = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      pending = pending + OUT_W'(tag_v[i]);
    end
    pc_src    = pc;
    fault_nxt = o_fault;
    if (i_redirect) begin
      count_nxt = '0;
      pending   = '0;
      pc_src    = redirect_pc;
      fault_nxt = misaligned;
    end
    issue_nxt = !fault_nxt && ((OUT_W'(count_nxt) + pending) < OUT_W'(DEPTH));

    // The registered head is the entry that will sit at the FIFO front after
    // this edge, which may be the word arriving right now into an empty queue.
    if (count_rem == '0) begin
      head_ok   = enq;
      head_insn = i_mem_data;
      head_pc   = tag_pc[MEM_LAT];
    end else begin
      head_ok   = 1'b1;
      head_insn = q_insn[head_nxt];
      head_pc   = q_pc[head_nxt];
    end
    if (i_redirect) begin
      head_ok = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc         <= RESET_PC;
      tag_v      <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      o_mem_read <= 1'b0;
      o_mem_addr <= '0;
      o_valid    <= 1'b0;
      o_insn     <= '0;
      o_pc       <= '0;
      o_fault    <= 1'b0;
    end else begin
      pc        <= issue_nxt ? pc_src + PC_W'(4) : pc_src;
      tag_v[0]  <= issue_nxt;
      tag_pc[0] <= pc_src;
      // A redirect kills every outstanding request; its data is simply dropped.
      for (int i = 1; i <= MEM_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1] & ~i_redirect;
        tag_pc[i] <= tag_pc[i-1];
      end
      if (i_redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          q_insn[tail] <= i_mem_data;
          q_pc[tail]   <= tag_pc[MEM_LAT];
          tail         <= tail + PTR_W'(1);
        end
        head  <= head_nxt;
        count <= count_nxt;
      end
      o_mem_read <= issue_nxt;
      if (issue_nxt) begin
        o_mem_addr <= pc_src[ADDR_W+1:2];
      end
      o_valid <= head_ok;
      if (head_ok) begin
        o_insn <= head_insn;
        o_pc   <= head_pc;
      end
      o_fault <= fault_nxt;
    end
  end

endmodule
